// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared FP32 definitions: rounding-mode encoding, fflags bit positions,
// common FP32 constants and the stage-1 pipeline payload.
// ----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_MAX  = 32'h7F7F_FFFF;
    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;
    localparam int          FP32_BIAS = 127;

    // Normalized beat held between the normalize and round stages.
    // exp is the unsigned biased exponent; 0 means subnormal.
    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [27:0] mant;
        logic        sticky;
        logic [2:0]  rm;
        logic        zero;
        logic        special;
        logic [31:0] sp_res;
        logic [4:0]  sp_flags;
    } s1_t;

endpackage

// File: rtl/fpu_round_norm_if.sv
// ----------------------------------------------------------------------------
// fpu_round_norm_if
// Valid/ready bus into and out of the normalize-and-round stage.
//   slave  : the rounding stage (consumes in_*, produces out_*)
//   master : the producer/consumer side around it
// ----------------------------------------------------------------------------
interface fpu_round_norm_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_sign_i;
    logic [9:0]  in_exp_i;
    logic [27:0] in_mant_i;
    logic        in_sticky_i;
    logic [2:0]  in_rm_i;
    logic        in_special_i;
    logic [31:0] in_special_res_i;
    logic [4:0]  in_special_flags_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_result_o;
    logic [4:0]  out_flags_o;

    modport slave (
        input  in_valid_i, in_sign_i, in_exp_i, in_mant_i, in_sticky_i, in_rm_i,
               in_special_i, in_special_res_i, in_special_flags_i, out_ready_i,
        output in_ready_o, out_valid_o, out_result_o, out_flags_o
    );

    modport master (
        output in_valid_i, in_sign_i, in_exp_i, in_mant_i, in_sticky_i, in_rm_i,
               in_special_i, in_special_res_i, in_special_flags_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_result_o, out_flags_o
    );
endinterface

// File: rtl/fpu_lzc28.sv
// ----------------------------------------------------------------------------
// fpu_lzc28
// Combinational leading-zero counter over a 28-bit mantissa.
//   i_mant : value to scan
//   o_cnt  : number of leading zeros (0 when i_mant is all-zero)
//   o_zero : i_mant is all-zero
// ----------------------------------------------------------------------------
module fpu_lzc28 (
    input  logic [27:0] i_mant,
    output logic [4:0]  o_cnt,
    output logic        o_zero
);
    // Scan upward so the highest set bit is the last assignment to win.
    always_comb begin
        o_cnt = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (i_mant[i]) o_cnt = 5'(27 - i);
        end
    end

    assign o_zero = ~|i_mant;
endmodule

// File: rtl/fpu_round_norm.sv
// ----------------------------------------------------------------------------
// fpu_round_norm
// Two-stage normalize/round pipeline for FP32 add/sub results.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : input beat {sign, exp, mant, sticky, rm, special bypass}
//                   with valid/ready; output {result, fflags} with valid/ready
// Stage 1 normalizes (and denormalizes when the exponent underflows);
// stage 2 rounds, detects overflow and forms the IEEE word and flags.
// ----------------------------------------------------------------------------
module fpu_round_norm
    import fpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    fpu_round_norm_if.slave bus
);
    // ---------------- stage 1: normalize ----------------
    logic [4:0]         w_lzc;
    logic               w_zero;
    logic [27:0]        w_norm;
    logic signed [10:0] w_e1;
    logic [10:0]        w_rsh;
    logic [55:0]        w_wide;
    s1_t                w_s1;

    fpu_lzc28 u_lzc (
        .i_mant (bus.in_mant_i),
        .o_cnt  (w_lzc),
        .o_zero (w_zero)
    );

    always_comb begin
        w_norm = bus.in_mant_i << w_lzc;
        w_e1   = $signed({bus.in_exp_i[9], bus.in_exp_i}) - $signed({6'b0, w_lzc});
        // Only meaningful when w_e1 <= 0, where 1 - w_e1 is positive.
        w_rsh  = 11'd1 - $unsigned(w_e1);
        if (w_rsh > 11'd28) w_rsh = 11'd28;
        // Low half collects the bits shifted out, for the sticky.
        w_wide = {w_norm, 28'b0} >> w_rsh;

        w_s1          = '0;
        w_s1.sign     = bus.in_sign_i;
        w_s1.rm       = bus.in_rm_i;
        w_s1.zero     = w_zero;
        w_s1.special  = bus.in_special_i;
        w_s1.sp_res   = bus.in_special_res_i;
        w_s1.sp_flags = bus.in_special_flags_i;
        if (w_e1 <= 11'sd0) begin
            w_s1.exp    = 10'd0;
            w_s1.mant   = w_wide[55:28];
            w_s1.sticky = bus.in_sticky_i | (|w_wide[27:0]);
        end else begin
            w_s1.exp    = w_e1[9:0];
            w_s1.mant   = w_norm;
            w_s1.sticky = bus.in_sticky_i;
        end
    end

    // ---------------- pipeline control ----------------
    logic r_s1_valid, r_s2_valid;
    s1_t  r_s1;
    logic [31:0] r_res;
    logic [4:0]  r_flags;
    logic w_s1_en, w_s2_en;

    assign w_s2_en = ~r_s2_valid | bus.out_ready_i;
    assign w_s1_en = ~r_s1_valid | w_s2_en;

    // ---------------- stage 2: round ----------------
    logic        w_guard, w_st, w_rup, w_ovf, w_nx, w_sat;
    logic [24:0] w_sum;
    logic [22:0] w_frac;
    logic [10:0] w_e2;
    logic [31:0] w_res;
    logic [4:0]  w_flags;

    always_comb begin
        w_guard = r_s1.mant[3];
        w_st    = (|r_s1.mant[2:0]) | r_s1.sticky;
        case (r_s1.rm)
            RM_RTZ:  w_rup = 1'b0;
            RM_RDN:  w_rup = r_s1.sign & (w_guard | w_st);
            RM_RUP:  w_rup = ~r_s1.sign & (w_guard | w_st);
            RM_RMM:  w_rup = w_guard;
            default: w_rup = w_guard & (w_st | r_s1.mant[4]);  // RNE and reserved
        endcase

        w_sum  = {1'b0, r_s1.mant[27:4]} + {24'b0, w_rup};
        w_frac = w_sum[22:0];
        w_e2   = {1'b0, r_s1.exp};
        if (w_sum[24]) begin
            w_frac = w_sum[23:1];
            w_e2   = w_e2 + 11'd1;
        end else if (r_s1.exp == 10'd0 && w_sum[23]) begin
            // subnormal rounded up to the smallest normal
            w_e2 = 11'd1;
        end

        w_ovf = (w_e2 >= 11'd255);
        w_nx  = w_guard | w_st | w_ovf;
        // Directed-away-from-infinity modes saturate to the largest finite.
        w_sat = (r_s1.rm == RM_RTZ) | ((r_s1.rm == RM_RDN) & ~r_s1.sign) |
                ((r_s1.rm == RM_RUP) & r_s1.sign);

        w_flags = '0;
        w_res   = {r_s1.sign, w_e2[7:0], w_frac};
        if (r_s1.special) begin
            w_res   = r_s1.sp_res;
            w_flags = r_s1.sp_flags;
        end else if (r_s1.zero) begin
            w_res = {r_s1.sign, 31'b0};
        end else if (w_ovf) begin
            w_res            = {r_s1.sign, w_sat ? FP32_MAX[30:0] : FP32_INF[30:0]};
            w_flags[FLAG_OF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else begin
            w_flags[FLAG_NX] = w_nx;
            w_flags[FLAG_UF] = w_nx & (w_e2 == 11'd0);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid_i;
            if (bus.in_valid_i) r_s1 <= w_s1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_flags    <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res   <= w_res;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.in_ready_o   = w_s1_en;
    assign bus.out_valid_o  = r_s2_valid;
    assign bus.out_result_o = r_res;
    assign bus.out_flags_o  = r_flags;
endmodule

// File: doc/fpu_round_norm.md
# fpu_round_norm

Normalize-and-round stage that sits directly downstream of the FP32 add/sub datapath. It accepts an unrounded result: sign, wide signed exponent, 28-bit mantissa and sticky bit. It produces the final IEEE-754 single-precision word and the RISC-V `fflags` bits. The block is a 2-stage valid/ready pipeline with full throughput. It also carries a special-case bypass, so NaN/Inf/zero results decided upstream pass through in order with regular results.

## Interface
- No parameters; all widths are fixed for FP32.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: stage can accept a beat.
- `in_sign_i` in 1: result sign.
- `in_exp_i` in 10: signed two's-complement biased exponent (127 = 2^0).
- `in_mant_i` in 28: unrounded mantissa; value = (mant / 2^27) · 2^(exp−127).
- `in_sticky_i` in 1: OR of bits already discarded upstream.
- `in_rm_i` in 3: rounding mode; RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
- `in_special_i` in 1: bypass; emit `in_special_res_i` / `in_special_flags_i` unchanged.
- `in_special_res_i` in 32: precomputed special result.
- `in_special_flags_i` in 5: precomputed flags.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `out_result_o` out 32: rounded FP32 result.
- `out_flags_o` out 5: {NV, DZ, OF, UF, NX}, bits 4..0.

## Operation
- **Stage 1 (normalize).**
  - Leading-zero count `lzc` over `in_mant_i`; shift left by `lzc`; `e1 = in_exp_i − lzc`.
  - If `e1 ≤ 0`: shift right by `1 − e1`, saturating at 28. Shifted-out bits OR into sticky. Set `e1 = 0` (subnormal).
  - If mantissa is zero: mark the beat zero; `e1` is ignored.
- **Stage 2 (round).**
  - Fields: `lsb` = m[4], `guard` = m[3], `sticky` = |m[2:0] | sticky.
  - Round-up decision by mode:
    - RNE: `guard & (sticky | lsb)`.
    - RTZ: never.
    - RDN: `sign & (guard | sticky)`.
    - RUP: `~sign & (guard | sticky)`.
    - RMM: `guard`.
  - Reserved `rm` values (101–111) round as RNE and raise no extra flag.
  - Add the round-up bit to m[27:4] (24 bits).
    - Carry out: shift right 1, e+1.
    - Subnormal rounding into bit 27: e becomes 1.
  - Result = {sign, e[7:0], m[26:4]}.
- **Overflow.** Triggered when e ≥ 255 after rounding.
  - Flags OF|NX.
  - Result is ±Inf, except magnitude 0x7F7FFFFF for RTZ, for RDN with positive sign, and for RUP with negative sign.
- **Flags.**
  - NX = guard | sticky | overflow.
  - UF = NX and final exponent field 0 (tininess after rounding).
  - NV and DZ are always 0 on the non-bypass path.
- **Zero mantissa.** Result is {sign, 31'b0}; flags 0.
- **Bypass.** When `in_special_i` is set, the special result and flags travel through both registers untouched, keeping order.

## Timing
- Latency is exactly 2 cycles from an accepted input (`in_valid_i & in_ready_o`) to `out_valid_o`, when unstalled.
- Throughput is 1 beat per cycle.
- Each stage register loads when it is empty or its content is leaving in the same cycle.
  - `in_ready_o = ~s1_valid | (~s2_valid | out_ready_i)`.
  - `in_ready_o` is combinational from `out_ready_i`.
- While `out_valid_o & ~out_ready_i`, `out_result_o` and `out_flags_o` hold stable.
- Both stages full and `out_ready_i` low: `in_ready_o` is 0 and no beat is lost or duplicated.
- A simultaneous accept and emit in the same cycle is legal, and order is preserved.
- Reset, including mid-operation:
  - Both valids clear immediately and asynchronously.
  - `out_result_o = 0`, `out_flags_o = 0`, `out_valid_o = 0`.
  - `in_ready_o` is 1 after release.
  - In-flight beats are dropped.

## Structure
- Shared package `fpu_pkg` holds:
  - the rounding-mode enum `rm_e`;
  - flag bit indices `FLAG_NV` .. `FLAG_NX`;
  - constants `FP32_QNAN = 0x7FC00000`, `FP32_MAX = 0x7F7FFFFF`, `FP32_INF = 0x7F800000`, `FP32_BIAS = 127`.
- One sub-module, `fpu_lzc28`: combinational 28-bit leading-zero counter with 5-bit count and all-zero flag.
- The stage 1 and stage 2 registers live in `fpu_round_norm`.

## Test plan
- **Exact one.** sign 0, exp 127, mant 0x8000000, RNE → 0x3F800000, flags 0x00, `out_valid_o` exactly 2 cycles after accept.
- **Ties under RNE.**
  - mant 0x8000018, exp 127 → 0x3F800002, flags 0x01.
  - mant 0x8000008 → 0x3F800000, flags 0x01.
  - Same 0x8000008 input with RUP → 0x3F800001.
- **Overflow.** exp 255, mant 0x8000000:
  - RNE → 0x7F800000, flags 0x05.
  - RTZ → 0x7F7FFFFF, flags 0x05.
  - Sign 1 with RUP → 0xFF7FFFFF, flags 0x05.
- **Subnormal.**
  - exp 0x3FE (−2), mant 0x8000000 → 0x00100000, flags 0x00.
  - Same with mant 0x8000001 → 0x00100000, flags 0x03 (UF|NX).
- **Backpressure and bypass.**
  - Stimulus: 4 back-to-back beats (3rd is special 0x7FC00000 with flags 0x10), `out_ready_i` held low for 4 cycles.
  - Required: `in_ready_o` drops when both stages are full; all 4 results emerge in order and unchanged.
- **Reset mid-flight.**
  - Stimulus: pull `rst_ni` low asynchronously, between clock edges, with both stages valid.
  - Required: `out_valid_o` falls before the next edge; after release no stale beat appears, and the next input returns its correct result 2 cycles later.
